// File: rtl/heap_pq_pkg.sv
// ============================================================================
// heap_pq_pkg
// Command encodings, FSM states and tree-index helpers for the heap queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

package heap_pq_pkg;

  localparam logic [1:0] OP_PUSH    = 2'b00;
  localparam logic [1:0] OP_POP     = 2'b01;
  localparam logic [1:0] OP_NOP     = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SIFT_UP   = 2'd1,
    ST_SIFT_DOWN = 2'd2
  } pq_state_t;

  function automatic logic [31:0] parent_idx(input logic [31:0] idx);
    return (idx - 32'd1) >> 1;
  endfunction

  function automatic logic [31:0] left_idx(input logic [31:0] idx);
    return (idx << 1) + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/heap_pq_better_sel.sv
// ============================================================================
// heap_pq_better_sel
// Picks the better of two children and flags whether it beats the parent.
// Revision: 1.0
// ============================================================================
`default_nettype none

module heap_pq_better_sel #(
  parameter int DATA_W   = 32,
  parameter int MIN_HEAP = 1
) (
  input  logic [DATA_W-1:0] parent_key_i,
  input  logic [DATA_W-1:0] left_key_i,
  input  logic [DATA_W-1:0] right_key_i,
  input  logic              left_vld_i,
  input  logic              right_vld_i,
  output logic              swap_o,
  output logic              sel_right_o
);

  logic [DATA_W-1:0] best_key;

  // Strict compare: equal keys never count as better, so ties never swap.
  function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (MIN_HEAP != 0) ? (a < b) : (a > b);
  endfunction

  always_comb begin
    sel_right_o = right_vld_i && (!left_vld_i || better(right_key_i, left_key_i));
    best_key    = sel_right_o ? right_key_i : left_key_i;
    swap_o      = (left_vld_i || right_vld_i) && better(best_key, parent_key_i);
  end

endmodule

`default_nettype wire

// File: rtl/heap_priority_queue.sv
// ============================================================================
// heap_priority_queue
// Binary-heap priority queue, one tree level of reordering per clock.
// Optional HEAP_PQ_PEEK_EN adds peek_valid/peek_data root-inspection ports.
// Revision: 1.0
// ============================================================================
`default_nettype none

module heap_priority_queue
  import heap_pq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 7,
  parameter int MIN_HEAP = 1
) (
  input  logic                       system1000,
  input  logic                       system1000_rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [DATA_W-1:0]          cmd_data,
  output logic                       resp_valid,
  output logic [DATA_W-1:0]          resp_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
`ifdef HEAP_PQ_PEEK_EN
  output logic                       err,
  output logic                       peek_valid,
  output logic [DATA_W-1:0]          peek_data
`else
  output logic                       err
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  pq_state_t         state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] heap_q [DEPTH];
  logic [DATA_W-1:0] heap_d [DEPTH];
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              err_q, err_d;

  logic [31:0]       w_l, w_r, w_b;
  logic [IW-1:0]     w_p, w_b_idx, w_tail, w_last;
  logic              w_l_vld, w_r_vld, w_b_inner;
  logic [DATA_W-1:0] w_l_key, w_r_key;
  logic              w_dn_swap, w_dn_sel_r, w_up_swap, w_up_sel_r;

  assign w_l     = left_idx(32'(idx_q));
  assign w_r     = w_l + 32'd1;
  assign w_p     = IW'(parent_idx(32'(idx_q)));
  assign w_l_vld = w_l < 32'(count_q);
  assign w_r_vld = w_r < 32'(count_q);
  assign w_l_key = (w_l < 32'(DEPTH)) ? heap_q[w_l[IW-1:0]] : '0;
  assign w_r_key = (w_r < 32'(DEPTH)) ? heap_q[w_r[IW-1:0]] : '0;
  assign w_b     = w_dn_sel_r ? w_r : w_l;
  assign w_b_idx = w_b[IW-1:0];
  // Finishing as soon as the moved key lands on a leaf (or the root) keeps
  // the busy time at floor(log2(DEPTH)) cycles.
  assign w_b_inner = left_idx(w_b) < 32'(count_q);
  assign w_tail  = IW'(count_q);
  assign w_last  = IW'(count_q - CW'(1));

  heap_pq_better_sel #(
    .DATA_W   (DATA_W),
    .MIN_HEAP (MIN_HEAP)
  ) u_sel_down (
    .parent_key_i (heap_q[idx_q]),
    .left_key_i   (w_l_key),
    .right_key_i  (w_r_key),
    .left_vld_i   (w_l_vld),
    .right_vld_i  (w_r_vld),
    .swap_o       (w_dn_swap),
    .sel_right_o  (w_dn_sel_r)
  );

  heap_pq_better_sel #(
    .DATA_W   (DATA_W),
    .MIN_HEAP (MIN_HEAP)
  ) u_sel_up (
    .parent_key_i (heap_q[w_p]),
    .left_key_i   (heap_q[idx_q]),
    .right_key_i  ('0),
    .left_vld_i   (1'b1),
    .right_vld_i  (1'b0),
    .swap_o       (w_up_swap),
    .sel_right_o  (w_up_sel_r)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idx_d        = idx_q;
    heap_d       = heap_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    err_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_PUSH: begin
              if (full) begin
                err_d = 1'b1;
              end else begin
                heap_d[w_tail] = cmd_data;
                idx_d          = w_tail;
                count_d        = count_q + CW'(1);
                if (count_q != '0) state_d = ST_SIFT_UP;
              end
            end
            OP_POP: begin
              if (empty) begin
                err_d = 1'b1;
              end else begin
                resp_data_d  = heap_q[0];
                resp_valid_d = 1'b1;
                heap_d[0]    = heap_q[w_last];
                count_d      = count_q - CW'(1);
                idx_d        = '0;
                if (count_q > CW'(2)) state_d = ST_SIFT_DOWN;
              end
            end
            OP_REPLACE: begin
              if (empty) begin
                err_d = 1'b1;
              end else begin
                resp_data_d  = heap_q[0];
                resp_valid_d = 1'b1;
                heap_d[0]    = cmd_data;
                idx_d        = '0;
                if (count_q > CW'(1)) state_d = ST_SIFT_DOWN;
              end
            end
            default: ;
          endcase
        end
      end
      ST_SIFT_UP: begin
        if (idx_q == '0 || !w_up_swap) begin
          state_d = ST_IDLE;
        end else begin
          heap_d[idx_q] = heap_q[w_p];
          heap_d[w_p]   = heap_q[idx_q];
          idx_d         = w_p;
          if (w_p == '0) state_d = ST_IDLE;
        end
      end
      ST_SIFT_DOWN: begin
        if (!w_dn_swap) begin
          state_d = ST_IDLE;
        end else begin
          heap_d[idx_q]   = heap_q[w_b_idx];
          heap_d[w_b_idx] = heap_q[idx_q];
          idx_d           = w_b_idx;
          if (!w_b_inner) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
    end
  end

  // Storage needs no reset: count alone decides which entries are live.
  always_ff @(posedge system1000) begin
    heap_q <= heap_d;
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign err        = err_q;

`ifdef HEAP_PQ_PEEK_EN
  assign peek_valid = (state_q == ST_IDLE) && !empty;
  assign peek_data  = peek_valid ? heap_q[0] : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_heap_priority_queue.sv
// ============================================================================
// tb_heap_priority_queue
// Directed table-driven bench: a min-heap and a max-heap instance, DEPTH=7.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_heap_priority_queue;
  import heap_pq_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 7;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_a, rst_b;
  logic          cmd_valid_a, cmd_valid_b;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;

  logic          ready_a, rv_a, empty_a, full_a, err_a;
  logic          ready_b, rv_b, empty_b, full_b, err_b;
  logic [DW-1:0] rd_a, rd_b;
  logic [CW-1:0] cnt_a, cnt_b;
`ifdef HEAP_PQ_PEEK_EN
  logic          pv_a, pv_b;
  logic [DW-1:0] pd_a, pd_b;
`endif

  always #5 clk = ~clk;

  heap_priority_queue #(.DATA_W(DW), .DEPTH(DEPTH), .MIN_HEAP(1)) u_dut_a (
    .system1000(clk), .system1000_rst(rst_a), .cmd_valid(cmd_valid_a),
    .cmd_ready(ready_a), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .resp_valid(rv_a), .resp_data(rd_a), .count(cnt_a), .empty(empty_a),
`ifdef HEAP_PQ_PEEK_EN
    .full(full_a), .err(err_a), .peek_valid(pv_a), .peek_data(pd_a)
`else
    .full(full_a), .err(err_a)
`endif
  );

  heap_priority_queue #(.DATA_W(DW), .DEPTH(DEPTH), .MIN_HEAP(0)) u_dut_b (
    .system1000(clk), .system1000_rst(rst_b), .cmd_valid(cmd_valid_b),
    .cmd_ready(ready_b), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .resp_valid(rv_b), .resp_data(rd_b), .count(cnt_b), .empty(empty_b),
`ifdef HEAP_PQ_PEEK_EN
    .full(full_b), .err(err_b), .peek_valid(pv_b), .peek_data(pd_b)
`else
    .full(full_b), .err(err_b)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit sel    = 1'b0;

  logic          m_ready, m_rv, m_err, m_empty, m_full;
  logic [DW-1:0] m_rd;
  logic [CW-1:0] m_cnt;

  always_comb begin
    m_ready = sel ? ready_b : ready_a;
    m_rv    = sel ? rv_b    : rv_a;
    m_err   = sel ? err_b   : err_a;
    m_empty = sel ? empty_b : empty_a;
    m_full  = sel ? full_b  : full_a;
    m_rd    = sel ? rd_b    : rd_a;
    m_cnt   = sel ? cnt_b   : cnt_a;
  end

  typedef struct {
    bit         dut;
    logic [1:0] op;
    logic [31:0] data;
    bit         rv;
    logic [31:0] rd;
    bit         err;
    int         cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input bit d, input logic [1:0] op, input int data,
                             input bit rv, input int rd, input bit e, input int cnt);
    vec_t t;
    t.dut = d; t.op = op; t.data = 32'(data); t.rv = rv; t.rd = 32'(rd);
    t.err = e; t.cnt = cnt;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_cmd(input string tag, input bit d, input logic [1:0] op,
                        input logic [31:0] data, input bit erv, input logic [31:0] erd,
                        input bit eerr, input int ecnt);
    int busy;
    sel = d; cmd_op = op; cmd_data = data;
    if (d) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
    @(posedge clk); #1;
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    check($sformatf("%s resp_valid", tag), 32'(m_rv), 32'(erv));
    if (erv) check($sformatf("%s resp_data", tag), m_rd, erd);
    check($sformatf("%s err", tag), 32'(m_err), 32'(eerr));
    check($sformatf("%s count", tag), 32'(m_cnt), 32'(ecnt));
    busy = 0;
    while (!m_ready && busy < 20) begin
      @(posedge clk); #1;
      busy++;
    end
    check($sformatf("%s busy<=2", tag), 32'(busy <= 2), 32'd1);
    @(posedge clk); #1;
    check($sformatf("%s single pulse", tag), {30'd0, m_rv, m_err}, 32'd0);
  endtask

  int stall_exp [7] = '{0, 0, 1, 1, 2, 2, 2};

  initial begin
    int stall;
    rst_a = 1'b1; rst_b = 1'b1;
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    cmd_op = OP_NOP; cmd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #0;
      check($sformatf("reset%0d count", d), 32'(m_cnt), 32'd0);
      check($sformatf("reset%0d empty/full", d), {30'd0, m_empty, m_full}, 32'd2);
      check($sformatf("reset%0d resp_valid/err", d), {30'd0, m_rv, m_err}, 32'd0);
      check($sformatf("reset%0d resp_data", d), m_rd, 32'd0);
      check($sformatf("reset%0d cmd_ready", d), 32'(m_ready), 32'd1);
    end

    tbl.push_back(v(0, OP_PUSH,    5, 0, 0, 0, 1));
    tbl.push_back(v(0, OP_PUSH,    3, 0, 0, 0, 2));
    tbl.push_back(v(0, OP_PUSH,    8, 0, 0, 0, 3));
    tbl.push_back(v(0, OP_PUSH,    1, 0, 0, 0, 4));
    tbl.push_back(v(0, OP_POP,     0, 1, 1, 0, 3));
    tbl.push_back(v(0, OP_POP,     0, 1, 3, 0, 2));
    tbl.push_back(v(0, OP_POP,     0, 1, 5, 0, 1));
    tbl.push_back(v(0, OP_POP,     0, 1, 8, 0, 0));
    tbl.push_back(v(0, OP_POP,     0, 0, 0, 1, 0));
    tbl.push_back(v(0, OP_NOP,    77, 0, 0, 0, 0));
    tbl.push_back(v(0, OP_PUSH,    2, 0, 0, 0, 1));
    tbl.push_back(v(0, OP_PUSH,    4, 0, 0, 0, 2));
    tbl.push_back(v(0, OP_PUSH,    6, 0, 0, 0, 3));
    tbl.push_back(v(0, OP_REPLACE, 9, 1, 2, 0, 3));
    tbl.push_back(v(0, OP_POP,     0, 1, 4, 0, 2));
    tbl.push_back(v(0, OP_POP,     0, 1, 6, 0, 1));
    tbl.push_back(v(0, OP_POP,     0, 1, 9, 0, 0));
    tbl.push_back(v(1, OP_PUSH,   10, 0, 0, 0, 1));
    tbl.push_back(v(1, OP_PUSH,   40, 0, 0, 0, 2));
    tbl.push_back(v(1, OP_PUSH,   20, 0, 0, 0, 3));
    tbl.push_back(v(1, OP_PUSH,   40, 0, 0, 0, 4));
    tbl.push_back(v(1, OP_POP,     0, 1, 40, 0, 3));
    tbl.push_back(v(1, OP_POP,     0, 1, 40, 0, 2));
    tbl.push_back(v(1, OP_POP,     0, 1, 20, 0, 1));
    tbl.push_back(v(1, OP_POP,     0, 1, 10, 0, 0));
    tbl.push_back(v(1, OP_REPLACE, 3, 0, 0, 1, 0));

    foreach (tbl[i])
      do_cmd($sformatf("vec%0d", i), tbl[i].dut, tbl[i].op, tbl[i].data,
             tbl[i].rv, tbl[i].rd, tbl[i].err, tbl[i].cnt);

    sel = 1'b0;
    #0;
    check("min empty after drain", 32'(m_empty), 32'd1);

    // Back-to-back pushes with valid held high; stall before each accept.
    cmd_op = OP_PUSH;
    cmd_valid_a = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cmd_data = 32'(7 - k);
      stall = 0;
      while (!ready_a && stall < 10) begin
        @(posedge clk); #1;
        stall++;
      end
      check($sformatf("fill stall before push %0d", 7 - k), 32'(stall), 32'(stall_exp[k]));
      @(posedge clk); #1;
    end
    cmd_valid_a = 1'b0;
    stall = 0;
    while (!ready_a && stall < 10) begin
      @(posedge clk); #1;
      stall++;
    end
    check("fill stall after push 1", 32'(stall), 32'd2);
    check("fill count", 32'(cnt_a), 32'd7);
    check("fill full", 32'(full_a), 32'd1);

    do_cmd("push when full", 1'b0, OP_PUSH, 32'd100, 1'b0, 32'd0, 1'b1, 7);
    check("full after overflow", 32'(full_a), 32'd1);
    for (int k = 1; k <= 7; k++)
      do_cmd($sformatf("drain pop %0d", k), 1'b0, OP_POP, 32'd0, 1'b1, 32'(k), 1'b0, 7 - k);

    // Reset in the middle of a sift-up.
    do_cmd("pre-reset push", 1'b0, OP_PUSH, 32'd10, 1'b0, 32'd0, 1'b0, 1);
    cmd_op = OP_PUSH; cmd_data = 32'd5; cmd_valid_a = 1'b1;
    @(posedge clk); #1;
    cmd_valid_a = 1'b0;
    check("busy during sift-up", 32'(ready_a), 32'd0);
    rst_a = 1'b1;
    #1;
    check("async reset count", 32'(cnt_a), 32'd0);
    check("async reset empty/ready", {30'd0, empty_a, ready_a}, 32'd3);
    @(negedge clk);
    rst_a = 1'b0;
    @(posedge clk); #1;
    check("post-reset ready", 32'(ready_a), 32'd1);
    check("post-reset count", 32'(cnt_a), 32'd0);
    do_cmd("post-reset pop", 1'b0, OP_POP, 32'd0, 1'b0, 32'd0, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
